// File: rtl/debug_byte_fifo.sv
// Debug byte FIFO: absorbs bursts of debug writes and feeds them one at a time
// to the hex-dump serial transmitter. Writes that arrive while full are counted.
module debug_byte_fifo #(
  parameter int depthBits = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           wrData,
  input  logic                 wrEn,
  output logic                 full,
  output logic                 empty,
  output logic [depthBits:0]   count,
  output logic [7:0]           dropCount,
  output logic [7:0]           txData,
  output logic                 txLoad,
  input  logic                 txReady,
  output logic [1:0]           fsmState
);

  localparam int Depth = 1 << depthBits;
  localparam logic [depthBits:0]   CountOne  = 1;
  localparam logic [depthBits:0]   CountFull = Depth;
  localparam logic [depthBits-1:0] PtrOne    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t               state, stateNext;
  logic [7:0]           mem [Depth];
  logic [depthBits-1:0] wrPtr, rdPtr;
  logic                 pop, push, drop;

  assign full     = (count == CountFull);
  assign empty    = (count == '0);
  assign fsmState = state;

  // Handshake with the transmitter: txLoad rises with txData valid and both
  // stay fixed until txReady is seen low (byte taken); the next load waits
  // until txReady has returned high (all characters sent).
  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty && txReady) begin
        pop       = 1'b1;
        stateNext = LOAD;
      end
      LOAD: if (!txReady) stateNext = WAIT;
      WAIT: if (txReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  assign push = wrEn && (!full || pop);
  assign drop = wrEn && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      dropCount <= '0;
      txData    <= '0;
      txLoad    <= 1'b0;
    end else begin
      state <= stateNext;
      if (push) wrPtr <= wrPtr + PtrOne;
      if (pop) begin
        rdPtr  <= rdPtr + PtrOne;
        txData <= mem[rdPtr];
      end
      case ({push, pop})
        2'b10:   count <= count + CountOne;
        2'b01:   count <= count - CountOne;
        default: count <= count;
      endcase
      if (drop && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
      if (pop) txLoad <= 1'b1;
      else if (state == LOAD && !txReady) txLoad <= 1'b0;
    end
  end

endmodule
